// File: rtl/os_integ_pkg.sv
// os_integ_pkg: FSM state, sign-extend and saturating-add helpers shared by os_integrator
package os_integ_pkg;
  localparam int MAX_W = 64;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input int w);
    logic [MAX_W-1:0] s;
    logic [MAX_W-1:0] lim;
    s = a + b;
    lim = (MAX_W'(1) << (w - 1)) - MAX_W'(!a[w-1]);
    return (a[w-1] == b[w-1] && s[w-1] != a[w-1]) ? lim : s;
  endfunction
endpackage

// File: rtl/os_integ_lane.sv
// os_integ_lane: one channel's sign-extend, add (clamped when OS_INTEG_SAT_EN is defined) and accumulator
module os_integ_lane import os_integ_pkg::*; #(
  parameter int IN_W = 6,
  parameter int ACC_W = 12
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  input logic add,
  input logic dump,
  input logic [IN_W-1:0] sample,
  output logic [ACC_W-1:0] sum
);
  logic [ACC_W-1:0] acc;
`ifdef OS_INTEG_SAT_EN
  assign sum = ACC_W'(sat_add(MAX_W'(acc), sext(MAX_W'(sample), IN_W), ACC_W));
`else
  assign sum = ACC_W'(MAX_W'(acc) + sext(MAX_W'(sample), IN_W));
`endif
  always_ff @(posedge clk) begin
    if (!rst_n || clear || dump) acc <= '0;
    else if (add) acc <= sum;
  end
endmodule

// File: rtl/os_integrator.sv
// os_integrator: multi-channel signed offset integrator with windowed dump, handshake and overrun (saturation via OS_INTEG_SAT_EN)
module os_integrator import os_integ_pkg::*; #(
  parameter int CHANNELS = 2,
  parameter int IN_W = 6,
  parameter int ACC_W = 12,
  parameter int PERIOD_W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  input logic [CHANNELS*IN_W-1:0] os_in,
  input logic [PERIOD_W-1:0] period,
  input logic clear,
  output logic out_valid,
  input logic out_ready,
  output logic [CHANNELS*ACC_W-1:0] out_data,
  output logic overrun
);
  state_t state, state_n;
  logic [PERIOD_W-1:0] cnt, win_len;
  logic [CHANNELS*ACC_W-1:0] sums;
  logic take, dump;
  always_comb begin
    take = state == RUN && in_valid && !clear;
    dump = take && cnt == win_len - PERIOD_W'(1);
    state_n = state == IDLE ? (period != '0 ? RUN : IDLE) : (dump && period == '0 ? IDLE : RUN);
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    os_integ_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .add(take),
      .dump(dump),
      .sample(os_in[c*IN_W +: IN_W]),
      .sum(sums[c*ACC_W +: ACC_W])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      win_len <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      if ((state == IDLE && period != '0) || dump) win_len <= period;
      cnt <= (state == IDLE || clear || dump) ? '0 : cnt + PERIOD_W'(take);
      if (dump) out_data <= sums;
      out_valid <= dump || (out_valid && !out_ready);
      overrun <= overrun || (dump && out_valid && !out_ready);
    end
  end
endmodule
